// File: rtl/uart_mon_pkg.sv
// Shared types and constants for the parametrised UART receive monitor.
package uart_mon_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  localparam logic [7:0] CH_EOT   = 8'h04;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;

  localparam int unsigned LINE_LEN = 80;

  // One receive FIFO entry: error flags plus the zero-extended character
  typedef struct packed {
    logic       ferr;
    logic       perr;
    logic [7:0] data;
  } rx_entry_t;

  function automatic logic is_line_end(input logic [7:0] ch);
    return (ch == CH_EOT) || (ch == CH_LF) || (ch == CH_CR);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Generic synchronous FIFO with extra-MSB pointers for full/empty detection.
module uart_rx_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic             push_ok_o,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             pop_en;
  logic             push_en;

  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_en    = pop_i & ~empty_o;
  // A full FIFO still takes a push when the head leaves in the same cycle
  assign push_en   = push_i & (~full_o | pop_en);
  assign push_ok_o = push_en;
  assign rdata_o   = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_en)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_en) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/uart_rx_mon_p.sv
// Parametrised UART receive monitor: oversampled RX FSM feeding a valid/ready FIFO.
// Optional console line printing is enabled by defining UART_MON_TEXT_EN.
module uart_rx_mon_p
  import uart_mon_pkg::*;
#(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY_MODE = 0,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       RXD,
  input  logic       BAUDTICK,
  output logic [7:0] RX_DATA,
  output logic       RX_PERR,
  output logic       RX_FERR,
  output logic       RX_VALID,
  input  logic       RX_READY,
  output logic       OVERRUN,
  output logic       BUSY
);

  localparam int unsigned      CNT_W     = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] CNT_MID   = CNT_W'(OVERSAMPLE / 2);
  localparam logic [2:0]       BIT_LAST  = 3'(DATA_BITS - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic             PAR_EXP   = (PARITY_MODE == PARITY_ODD);
  localparam int unsigned      ENTRY_W   = $bits(rx_entry_t);

  rx_state_e        state_q;
  logic             rxd_meta_q;
  logic             rxd_sync_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       data_q;
  logic             perr_q;
  logic             ferr_q;
  logic             stop_idx_q;
  logic             overrun_q;

  logic             sample_c;
  logic             push_c;
  logic             push_ok_c;
  logic             fifo_full_c;
  logic             fifo_empty_c;
  logic [ENTRY_W-1:0] fifo_rdata_c;
  rx_entry_t        push_entry_c;
  rx_entry_t        head_c;

  assign sample_c = BAUDTICK && (cnt_q == CNT_LAST);
  assign push_c   = (state_q == STOP) && sample_c && (stop_idx_q == STOP_LAST);

  // Final stop-bit sample is folded into the pushed framing flag
  always_comb begin
    push_entry_c      = '0;
    push_entry_c.ferr = ferr_q | ~rxd_sync_q;
    push_entry_c.perr = perr_q;
    push_entry_c.data = data_q;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      data_q     <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      stop_idx_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      rxd_meta_q <= RXD;
      rxd_sync_q <= rxd_meta_q;
      overrun_q  <= push_c & ~push_ok_c;

      // Start edge re-phases the counter so samples land mid-bit
      if ((state_q == IDLE) && !rxd_sync_q) begin
        cnt_q <= CNT_MID;
      end else if (BAUDTICK) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end

      case (state_q)
        IDLE: begin
          if (!rxd_sync_q) begin
            state_q    <= START;
            bit_idx_q  <= '0;
            data_q     <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            stop_idx_q <= 1'b0;
          end
        end
        START: begin
          if (sample_c) begin
            if (rxd_sync_q) begin
              state_q <= IDLE;
            end else begin
              state_q   <= DATA;
              bit_idx_q <= '0;
            end
          end
        end
        DATA: begin
          if (sample_c) begin
            data_q[bit_idx_q] <= rxd_sync_q;
            if (bit_idx_q == BIT_LAST) begin
              state_q <= (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'(1);
            end
          end
        end
        PARITY: begin
          if (sample_c) begin
            perr_q  <= ((^data_q) ^ rxd_sync_q) != PAR_EXP;
            state_q <= STOP;
          end
        end
        STOP: begin
          if (sample_c) begin
            ferr_q <= ferr_q | ~rxd_sync_q;
            if (stop_idx_q == STOP_LAST) begin
              state_q <= IDLE;
            end else begin
              stop_idx_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  uart_rx_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (CLK),
    .rst_i     (RESET),
    .push_i    (push_c),
    .wdata_i   (push_entry_c),
    .pop_i     (RX_READY),
    .push_ok_o (push_ok_c),
    .rdata_o   (fifo_rdata_c),
    .full_o    (fifo_full_c),
    .empty_o   (fifo_empty_c)
  );

  // Head entry is masked while empty so stale RAM never reaches the outputs
  assign head_c   = rx_entry_t'(fifo_rdata_c);
  assign RX_VALID = ~fifo_empty_c;
  assign RX_DATA  = RX_VALID ? head_c.data : 8'h00;
  assign RX_PERR  = RX_VALID & head_c.perr;
  assign RX_FERR  = RX_VALID & head_c.ferr;
  assign OVERRUN  = overrun_q;
  assign BUSY     = (state_q != IDLE);

`ifdef UART_MON_TEXT_EN
  string line_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      line_q <= "";
    end else if (push_ok_c) begin
      if (push_entry_c.ferr || push_entry_c.perr) begin
        $write("%t UART: frame error 0x%h\n", $time, push_entry_c.data);
      end else if (is_line_end(push_entry_c.data) || (line_q.len() == int'(LINE_LEN - 1))) begin
        $write("%t UART: %s\n", $time, $sformatf("%s%c", line_q,
               is_line_end(push_entry_c.data) ? CH_SPACE : push_entry_c.data));
        line_q <= "";
        if (push_entry_c.data == CH_EOT) begin
          $write("UART: Simulation End\n");
          $finish;
        end
      end else begin
        line_q <= $sformatf("%s%c", line_q, push_entry_c.data);
      end
    end
  end
`else
  logic unused_fifo_full_c;
  assign unused_fifo_full_c = fifo_full_c;
`endif

endmodule

// File: tb/tb_uart_rx_mon_p.sv
// Directed bench: default 8N1 instance plus a 7E2 instance sharing clock and BAUDTICK.
module tb_uart_rx_mon_p;

  logic       clk = 1'b0;
  logic       rst;
  logic       baud_en;
  logic       div_q = 1'b0;
  logic       baudtick;
  logic       rxd_a, rxd_b;
  logic       rdy_a, rdy_b;
  logic [7:0] data_a, data_b;
  logic       perr_a, perr_b, ferr_a, ferr_b;
  logic       vld_a, vld_b, ovr_a, ovr_b, busy_a, busy_b;

  int n_chk  = 0;
  int n_pass = 0;

  logic [9:0] q_a[$];
  logic [9:0] q_b[$];
  int vcyc_a = 0;
  int novr_a = 0;
  int novr_b = 0;

  always #5 clk = ~clk;

  always @(posedge clk) div_q <= ~div_q;
  assign baudtick = div_q & baud_en;

  uart_rx_mon_p u_a (
    .CLK(clk), .RESET(rst), .RXD(rxd_a), .BAUDTICK(baudtick),
    .RX_DATA(data_a), .RX_PERR(perr_a), .RX_FERR(ferr_a), .RX_VALID(vld_a),
    .RX_READY(rdy_a), .OVERRUN(ovr_a), .BUSY(busy_a)
  );

  uart_rx_mon_p #(.DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2)) u_b (
    .CLK(clk), .RESET(rst), .RXD(rxd_b), .BAUDTICK(baudtick),
    .RX_DATA(data_b), .RX_PERR(perr_b), .RX_FERR(ferr_b), .RX_VALID(vld_b),
    .RX_READY(rdy_b), .OVERRUN(ovr_b), .BUSY(busy_b)
  );

  // Capture every popped entry as {ferr, perr, data}
  always @(negedge clk) begin
    if (vld_a && rdy_a) q_a.push_back({ferr_a, perr_a, data_a});
    if (vld_b && rdy_b) q_b.push_back({ferr_b, perr_b, data_b});
    if (vld_a) vcyc_a <= vcyc_a + 1;
    if (ovr_a) novr_a <= novr_a + 1;
    if (ovr_b) novr_b <= novr_b + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_line(input int inst, input logic b);
    if (inst == 0) rxd_a = b;
    else rxd_b = b;
  endtask

  task automatic tx_bit(input int inst, input logic b);
    set_line(inst, b);
    repeat (32) step();
  endtask

  function automatic logic [9:0] qa_at(input int i);
    return (i < q_a.size()) ? q_a[i] : 10'h3FF;
  endfunction

  function automatic logic [9:0] qb_at(input int i);
    return (i < q_b.size()) ? q_b[i] : 10'h3FF;
  endfunction

  // Send one frame; the last stop bit is held until BUSY drops, then the line idles.
  // pulse raises rdy_a for exactly the push cycle of instance a.
  task automatic tx_frame(input int inst, input logic [7:0] d, input int nbits,
                          input int par, input logic last_stop, input int nstop,
                          input bit pulse, output logic vld_at_idle);
    bit done;
    tx_bit(inst, 1'b0);
    for (int i = 0; i < nbits; i++) tx_bit(inst, d[i]);
    if (par >= 0) tx_bit(inst, par[0]);
    for (int s = 0; s < nstop - 1; s++) tx_bit(inst, 1'b1);
    set_line(inst, last_stop);
    done = 1'b0;
    for (int i = 0; i < 80; i++) begin
      step();
      if (pulse) rdy_a = u_a.push_c;
      if (!((inst == 0) ? busy_a : busy_b)) begin
        done = 1'b1;
        break;
      end
    end
    vld_at_idle = (inst == 0) ? vld_a : vld_b;
    chk("frame_done", 32'(done), 32'd1);
    set_line(inst, 1'b1);
    repeat (64) step();
  endtask

  initial begin
    int qa0, qb0, v0, o0;
    logic v;
    rst = 1'b1; baud_en = 1'b1;
    rxd_a = 1'b1; rxd_b = 1'b1;
    rdy_a = 1'b1; rdy_b = 1'b1;
    repeat (3) step();
    chk("rst_valid", 32'(vld_a), 32'd0);
    chk("rst_data",  32'(data_a), 32'd0);
    chk("rst_flags", 32'({perr_a, ferr_a}), 32'd0);
    chk("rst_ovr",   32'(ovr_a), 32'd0);
    chk("rst_busy",  32'({busy_a, busy_b}), 32'd0);
    rst = 1'b0;
    repeat (5) step();

    // 8N1 characters with the consumer always ready
    qa0 = q_a.size(); v0 = vcyc_a;
    tx_frame(0, 8'h41, 8, -1, 1'b1, 1, 1'b0, v);
    tx_frame(0, 8'h0A, 8, -1, 1'b1, 1, 1'b0, v);
    chk("t1_count", 32'(q_a.size() - qa0), 32'd2);
    chk("t1_ent0", 32'(qa_at(qa0)), 32'h041);
    chk("t1_ent1", 32'(qa_at(qa0 + 1)), 32'h00A);
    chk("t1_vcyc", 32'(vcyc_a - v0), 32'd2);

    // 7 data bits, even parity, two stop bits
    qb0 = q_b.size();
    tx_frame(1, 8'h55, 7, 0, 1'b1, 2, 1'b0, v);
    tx_frame(1, 8'h55, 7, 1, 1'b1, 2, 1'b0, v);
    tx_frame(1, 8'h33, 7, 0, 1'b0, 2, 1'b0, v);
    tx_frame(1, 8'h34, 7, 1, 1'b1, 2, 1'b0, v);
    chk("t2_count", 32'(q_b.size() - qb0), 32'd4);
    chk("t2_par_ok",  32'(qb_at(qb0)), 32'h055);
    chk("t2_par_bad", 32'(qb_at(qb0 + 1)), 32'h155);
    chk("t3_ferr",    32'(qb_at(qb0 + 2)), 32'h233);
    chk("t3_clean",   32'(qb_at(qb0 + 3)), 32'h034);
    chk("t3_no_ovr",  32'(novr_b), 32'd0);

    // Fill the FIFO with the consumer stalled; fifth frame overruns
    rdy_a = 1'b0;
    qa0 = q_a.size(); o0 = novr_a;
    tx_frame(0, 8'h01, 8, -1, 1'b1, 1, 1'b0, v);
    chk("t4_latency", 32'(v), 32'd1);
    chk("t4_head", 32'(data_a), 32'h01);
    tx_frame(0, 8'h02, 8, -1, 1'b1, 1, 1'b0, v);
    tx_frame(0, 8'h03, 8, -1, 1'b1, 1, 1'b0, v);
    tx_frame(0, 8'h04, 8, -1, 1'b1, 1, 1'b0, v);
    chk("t4_no_ovr_yet", 32'(novr_a - o0), 32'd0);
    tx_frame(0, 8'h05, 8, -1, 1'b1, 1, 1'b0, v);
    chk("t4_ovr_pulse", 32'(novr_a - o0), 32'd1);
    chk("t4_valid", 32'(vld_a), 32'd1);
    chk("t4_head_kept", 32'(data_a), 32'h01);

    // Full FIFO: push and pop in the same cycle
    tx_frame(0, 8'h06, 8, -1, 1'b1, 1, 1'b1, v);
    chk("t6_no_ovr", 32'(novr_a - o0), 32'd1);
    chk("t6_head", 32'(data_a), 32'h02);
    rdy_a = 1'b1;
    repeat (8) step();
    chk("t6_drained", 32'(vld_a), 32'd0);
    chk("t6_count", 32'(q_a.size() - qa0), 32'd5);
    chk("t6_e0", 32'(qa_at(qa0)),     32'h001);
    chk("t6_e1", 32'(qa_at(qa0 + 1)), 32'h002);
    chk("t6_e2", 32'(qa_at(qa0 + 2)), 32'h003);
    chk("t6_e3", 32'(qa_at(qa0 + 3)), 32'h004);
    chk("t6_e4", 32'(qa_at(qa0 + 4)), 32'h006);

    // Start-bit glitch of 4 BAUDTICKs is rejected
    qa0 = q_a.size();
    rxd_a = 1'b0;
    repeat (8) step();
    chk("t5_glitch_busy", 32'(busy_a), 32'd1);
    rxd_a = 1'b1;
    repeat (40) step();
    chk("t5_glitch_idle", 32'(busy_a), 32'd0);
    chk("t5_glitch_nopush", 32'(q_a.size() - qa0), 32'd0);

    // No BAUDTICK: FSM freezes in START
    baud_en = 1'b0;
    rxd_a = 1'b0;
    repeat (8) step();
    rxd_a = 1'b1;
    repeat (200) step();
    chk("freeze_busy", 32'(busy_a), 32'd1);
    baud_en = 1'b1;
    repeat (40) step();
    chk("freeze_release", 32'(busy_a), 32'd0);
    chk("freeze_nopush", 32'(vld_a), 32'd0);

    // Reset mid-data discards FIFO contents and the partial frame
    rdy_a = 1'b0;
    tx_frame(0, 8'h77, 8, -1, 1'b1, 1, 1'b0, v);
    chk("rst_pre_valid", 32'(vld_a), 32'd1);
    tx_bit(0, 1'b0);
    tx_bit(0, 1'b1);
    tx_bit(0, 1'b0);
    chk("rst_pre_busy", 32'(busy_a), 32'd1);
    rst = 1'b1;
    rxd_a = 1'b1;
    step();
    chk("rst_mid_valid", 32'(vld_a), 32'd0);
    chk("rst_mid_data",  32'(data_a), 32'd0);
    chk("rst_mid_flags", 32'({perr_a, ferr_a, ovr_a}), 32'd0);
    chk("rst_mid_busy",  32'(busy_a), 32'd0);
    rst = 1'b0;
    repeat (400) step();
    chk("rst_post_valid", 32'(vld_a), 32'd0);
    chk("rst_post_busy",  32'(busy_a), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_rx_mon_p.md
Name: uart_rx_mon_p

Overview:
Parametrised UART receive monitor for the simulation environment. It is the successor to the fixed 8N1 text monitor.
It oversamples a serial RXD line using an external BAUDTICK strobe and supports configurable data width, parity and stop bits.
Received characters, with per-character error status, are buffered in a small FIFO behind a valid/ready interface, so testbench checkers can consume them.
Console text printing is an optional compile-time feature.

Parameters:
DATA_BITS, 8, data bits per frame; legal 5..8.
PARITY_MODE, 0, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, stop bits checked; legal 1 or 2.
OVERSAMPLE, 16, BAUDTICKs per bit; power of 2, legal 4..64.
FIFO_DEPTH, 4, receive FIFO entries; power of 2, legal 2..16.

Ports:
CLK  in  1  clock
RESET  in  1  synchronous active-high reset
RXD  in  1  serial input, idle high
BAUDTICK  in  1  one-CLK strobe, OVERSAMPLE per bit period
RX_DATA  out  8  head-of-FIFO character; bits above DATA_BITS-1 read 0
RX_PERR  out  1  parity error flag of the head entry
RX_FERR  out  1  framing error flag of the head entry
RX_VALID  out  1  FIFO not empty
RX_READY  in  1  consumer accepts the head entry
OVERRUN  out  1  one-cycle pulse: a completed frame was dropped because the FIFO was full
BUSY  out  1  FSM not in IDLE

Behaviour:
- Reset and clocking: one clock, CLK. Reset is synchronous, active-high, on port RESET.
- Reset values: FSM = IDLE, FIFO empty, RX_VALID = 0, RX_DATA = 0, RX_PERR = 0, RX_FERR = 0, OVERRUN = 0, BUSY = 0, tick counter = 0, synchroniser flops = 1.
- Reset applied mid-frame discards the partial frame and all FIFO contents.
- Input synchronisation: RXD passes through a 2-flop synchroniser. All references to RXD below mean the synchronised value.
- Tick counter: width log2(OVERSAMPLE). It increments on BAUDTICK and wraps OVERSAMPLE-1 -> 0. A "sample" occurs on a BAUDTICK while the counter equals OVERSAMPLE-1.
- IDLE:
  - RXD == 0 -> START; counter loaded with OVERSAMPLE/2.
  - The first sample therefore lands mid start bit.
- START, at sample:
  - RXD == 1 -> IDLE (glitch rejected, nothing pushed, no error).
  - RXD == 0 -> DATA, bit index = 0.
- DATA, at each sample:
  - Shift RXD in LSB first.
  - After bit DATA_BITS-1 -> PARITY if PARITY_MODE != 0, else STOP.
- PARITY, at sample:
  - perr = (XOR of data bits XOR RXD) != expected.
  - Expected value is 1 for odd parity, 0 for even parity.
  - Then go to STOP.
- STOP, at each sample:
  - ferr |= ~RXD.
  - After STOP_BITS samples, push {ferr, perr, data} and go to IDLE.
  - In IDLE, a new start edge is detected no earlier than the next cycle.
- Latency: the pushed entry is visible on RX_VALID/RX_DATA the cycle after the final stop-bit sample.
- FIFO behaviour:
  - Pop on RX_VALID & RX_READY.
  - Push is accepted when not full, or when full with a pop in the same cycle.
  - A push while full and not popping drops the new frame and pulses OVERRUN for 1 cycle.
  - Simultaneous push and pop on an empty FIFO is impossible: RX_VALID is 0, so the push lands and RX_VALID rises the next cycle.
  - RX_READY with RX_VALID = 0 is ignored.
  - Read and write pointers are log2(FIFO_DEPTH)+1 bits. Full and empty are derived from the MSB/equal comparison.
- BAUDTICK held low: the FSM freezes in its current state indefinitely. There is no timeout.

Optional Feature:
UART_MON_TEXT_EN
- Defined:
  - Every accepted push is also appended to an internal 80-entry line buffer.
  - Characters 0x0A, 0x0D and 0x04 are stored as space (0x20).
  - On 0x0A, 0x0D, 0x04, or when the line reaches 80 characters, the line prints via $write as "%t UART: <text>" and the buffer clears.
  - 0x04 additionally prints "UART: Simulation End" and calls $finish.
  - Frames with RX_FERR or RX_PERR print "UART: frame error 0x%h" instead of being buffered.
- Undefined: no line buffer, no system tasks; the block is fully synthesisable.

Decomposition:
- Package uart_mon_pkg:
  - FSM state encoding: IDLE, START, DATA, PARITY, STOP.
  - PARITY_NONE / ODD / EVEN constants.
  - Control character constants: EOT = 0x04, LF, CR, SPACE.
  - Line length constant: 80.
- Sub-module uart_rx_fifo: generic synchronous FIFO, parametrised by width and depth, with push/pop/full/empty.

Test Plan:
1. Defaults, send 0x41 then 0x0A at OVERSAMPLE=16 with RX_READY=1 -> two entries 0x41, 0x0A; PERR = FERR = 0; RX_VALID high 1 cycle each. With TEXT_EN, prints "UART: A ".
2. PARITY_MODE=2, DATA_BITS=7: send 0x55 with correct parity bit 0 -> PERR = 0. Then send 0x55 with parity bit 1 -> PERR = 1, data 0x55.
3. STOP_BITS=2: send 0x33 with second stop bit 0 -> entry 0x33 with FERR = 1. Next frame 0x34 is clean -> FERR = 0.
4. RX_READY=0, FIFO_DEPTH=4, send 5 frames 0x01..0x05 -> RX_VALID = 1; 5th frame dropped with a 1-cycle OVERRUN. Then raise RX_READY -> pops 0x01..0x04 only.
5. RXD low for 4 BAUDTICKs, then high -> no push, BUSY returns to 0 at the mid-start sample. Assert RESET mid-data of a frame -> FIFO empty, no push, all outputs at reset values next cycle.
6. Full FIFO with push and pop in the same cycle -> no OVERRUN, occupancy unchanged, new byte stored at the tail.
